// File: rtl/quick_cpu_core.sv
// Multi-cycle accumulator-free CPU: four DATA_W registers, Z/C flags, and one
// shared instruction/data memory port with a ready handshake that tolerates wait states.
module quick_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_JZ  = 4'h4;
    localparam logic [3:0] OP_JC  = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [4];
    logic [7:0]        ir;
    logic              z, c;

    logic [3:0]        op;
    logic [1:0]        le, ri;
    logic [DATA_W-1:0] a, b;
    logic [ADDR_W-1:0] pc_inc1, pc_inc2, ri_addr;
    logic [DATA_W:0]   alu_res;

    // Top bit of the result is the new carry: carry-out for ADD, borrow for SUB, 0 for logic ops.
    function automatic logic [DATA_W:0] alu(input logic [3:0] f,
                                            input logic [DATA_W-1:0] x,
                                            input logic [DATA_W-1:0] y);
        logic [DATA_W:0] r;
        case (f)
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            OP_SUB:  r = {1'b0, x} - {1'b0, y};
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_XOR:  r = {1'b0, x ^ y};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign op      = ir[7:4];
    assign le      = ir[3:2];
    assign ri      = ir[1:0];
    assign a       = regs[le];
    assign b       = regs[ri];
    assign ri_addr = b[ADDR_W-1:0];
    assign pc_inc1 = pc + ADDR_W'(1);
    assign pc_inc2 = pc + ADDR_W'(2);
    assign alu_res = alu(op, a, b);

    assign halted = (state == S_HALT);
    assign dbg_pc = pc;
    assign flag_z = z;
    assign flag_c = c;

    // Request outputs depend only on state and registers, never on mem_ready/mem_rdata.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        case (state)
            S_FETCH: mem_rd = 1'b1;
            S_MEM: begin
                if (op == OP_ST) begin
                    mem_wr    = 1'b1;
                    mem_addr  = ri_addr;
                    mem_wdata = a;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = (op == OP_LDI) ? pc_inc1 : ri_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[7:0];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc_inc1;
                    case (op)
                        OP_LD, OP_ST, OP_LDI: begin
                            state <= S_MEM;
                            pc    <= pc;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            regs[le] <= alu_res[DATA_W-1:0];
                            z        <= (alu_res[DATA_W-1:0] == '0);
                            c        <= alu_res[DATA_W];
                        end
                        OP_JZ:  if (a == '0) pc <= ri_addr;
                        OP_JC:  if (c) pc <= ri_addr;
                        OP_MOV: regs[le] <= b;
                        OP_HLT: begin
                            state <= S_HALT;
                            pc    <= pc;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                        case (op)
                            OP_LD: begin
                                regs[le] <= mem_rdata;
                                pc       <= pc_inc1;
                            end
                            OP_LDI: begin
                                regs[le] <= mem_rdata;
                                pc       <= pc_inc2;
                            end
                            default: pc <= pc_inc1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quick_cpu_core.sv
// Bench for quick_cpu_core: directed programs plus random memory images, checked
// cycle by cycle against an instruction-level model of the CPU and its memory.
module tb_quick_cpu_core;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;
    logic          halted;
    logic [AW-1:0] dbg_pc;
    logic          flag_z, flag_c;

    quick_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .dbg_pc(dbg_pc), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: memory image, registers, PC and flags.
    logic [7:0] mem [256];
    int         r [4];
    int         pc;
    bit         mz, mc, mhalt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the memory response for one cycle, then return just after the falling edge.
    task automatic step(input bit rdy);
        mem_ready = rdy;
        mem_rdata = rdy ? mem[mem_addr] : 8'($urandom);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) r[i] = 0;
        pc = 0; mz = 0; mc = 0; mhalt = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        mem_rdata = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_exec(input logic [7:0] ins);
        int op, le, ri, res;
        op = int'(ins[7:4]); le = int'(ins[3:2]); ri = int'(ins[1:0]);
        case (op)
            0: begin r[le] = int'(mem[r[ri]]); pc = (pc + 1) % 256; end
            1: begin mem[r[ri]] = 8'(r[le]); pc = (pc + 1) % 256; end
            2: begin
                mc = (r[le] < r[ri]);
                res = r[le] - r[ri];
                if (res < 0) res += 256;
                r[le] = res; mz = (res == 0); pc = (pc + 1) % 256;
            end
            3: begin
                res = r[le] + r[ri];
                mc = (res > 255);
                r[le] = res % 256; mz = (r[le] == 0); pc = (pc + 1) % 256;
            end
            4: pc = (r[le] == 0) ? r[ri] : (pc + 1) % 256;
            5: pc = mc ? r[ri] : (pc + 1) % 256;
            6: begin r[le] = int'(mem[(pc + 1) % 256]); pc = (pc + 2) % 256; end
            7: begin r[le] = r[ri]; pc = (pc + 1) % 256; end
            8, 9, 10: begin
                if (op == 8)      res = r[le] & r[ri];
                else if (op == 9) res = r[le] | r[ri];
                else              res = r[le] ^ r[ri];
                r[le] = res; mz = (res == 0); mc = 0; pc = (pc + 1) % 256;
            end
            15: mhalt = 1;
            default: pc = (pc + 1) % 256;
        endcase
    endtask

    // One instruction with wf fetch wait cycles and wm memory-phase wait cycles.
    task automatic run_instr(input int wf, input int wm);
        logic [7:0] ins;
        int op, le, ri, ea;
        ins = mem[pc];
        op = int'(ins[7:4]); le = int'(ins[3:2]); ri = int'(ins[1:0]);
        for (int i = 0; i <= wf; i++) begin
            chk("fetch_rd", 32'(mem_rd), 1);
            chk("fetch_wr", 32'(mem_wr), 0);
            chk("fetch_addr", 32'(mem_addr), pc);
            chk("fetch_wdata", 32'(mem_wdata), 0);
            step(i == wf);
        end
        chk("exec_rd", 32'(mem_rd), 0);
        chk("exec_wr", 32'(mem_wr), 0);
        step(1'($urandom_range(0, 1)));
        if (op == 0 || op == 1 || op == 6) begin
            ea = (op == 6) ? (pc + 1) % 256 : r[ri];
            for (int i = 0; i <= wm; i++) begin
                chk("mem_rd", 32'(mem_rd), (op != 1) ? 1 : 0);
                chk("mem_wr", 32'(mem_wr), (op == 1) ? 1 : 0);
                chk("mem_addr", 32'(mem_addr), ea);
                chk("mem_wdata", 32'(mem_wdata), (op == 1) ? r[le] : 0);
                step(i == wm);
            end
        end
        model_exec(ins);
        chk("pc", 32'(dbg_pc), pc);
        chk("flag_z", 32'(flag_z), 32'(mz));
        chk("flag_c", 32'(flag_c), 32'(mc));
        chk("halted", 32'(halted), 32'(mhalt));
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // LDI r0,FF; LDI r1,01; ADD r0,r1; ST [r1],r0
        mem[0] = 8'h60; mem[1] = 8'hFF; mem[2] = 8'h64; mem[3] = 8'h01;
        mem[4] = 8'h31; mem[5] = 8'h11;
        // LDI r2,3; LDI r3,5; SUB r2,r3; LDI r1,20; JC r1
        mem[6] = 8'h68; mem[7] = 8'h03; mem[8] = 8'h6C; mem[9] = 8'h05;
        mem[10] = 8'h2B; mem[11] = 8'h64; mem[12] = 8'h20; mem[13] = 8'h51;
        // LDI r1,40; LDI r0,A5; ST [r1],r0; LDI r2,FF; LDI r3,0; JZ r3,r2
        mem[8'h20] = 8'h64; mem[8'h21] = 8'h40; mem[8'h22] = 8'h60; mem[8'h23] = 8'hA5;
        mem[8'h24] = 8'h11; mem[8'h25] = 8'h68; mem[8'h26] = 8'hFF; mem[8'h27] = 8'h6C;
        mem[8'h28] = 8'h00; mem[8'h29] = 8'h4E;
        mem[8'hFF] = 8'h60;

        do_reset();
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rd", 32'(mem_rd), 1);
        chk("rst_wr", 32'(mem_wr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_z", 32'(flag_z), 0);
        chk("rst_c", 32'(flag_c), 0);

        run_instr(0, 0); run_instr(0, 0); run_instr(0, 0);
        chk("add_pc", 32'(dbg_pc), 5);
        chk("add_z", 32'(flag_z), 1);
        chk("add_c", 32'(flag_c), 1);
        run_instr(0, 0);

        run_instr(0, 0); run_instr(1, 2); run_instr(0, 0);
        chk("sub_c", 32'(flag_c), 1);
        chk("sub_z", 32'(flag_z), 0);
        run_instr(0, 0); run_instr(2, 0);
        chk("jc_pc", 32'(dbg_pc), 32'h20);

        run_instr(0, 0); run_instr(0, 0);
        run_instr(0, 3);
        chk("st_mem", 32'(mem[8'h40]), 32'hA5);

        run_instr(0, 0); run_instr(0, 0); run_instr(0, 0);
        chk("jz_pc", 32'(dbg_pc), 32'hFF);
        run_instr(0, 1);
        chk("ldi_wrap_pc", 32'(dbg_pc), 1);

        mem[1] = 8'hF0;
        run_instr(1, 0);
        for (int i = 0; i < 20; i++) begin
            chk("halt_flag", 32'(halted), 1);
            chk("halt_rd", 32'(mem_rd), 0);
            chk("halt_wr", 32'(mem_wr), 0);
            chk("halt_pc", 32'(dbg_pc), 1);
            step(1'($urandom_range(0, 1)));
        end

        // LD r1,[r0] stalled in its memory phase, then aborted by reset.
        mem[0] = 8'h04;
        do_reset();
        chk("ld_fetch_addr", 32'(mem_addr), 0);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("ld_stall_rd", 32'(mem_rd), 1);
            chk("ld_stall_addr", 32'(mem_addr), 0);
            step(1'b0);
        end
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h04;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_rd", 32'(mem_rd), 1);
        chk("abort_pc", 32'(dbg_pc), 0);
        mem[0] = 8'h46;
        run_instr(0, 0);
        chk("abort_no_wb", 32'(dbg_pc), 0);

        // Random memory images run against the model; halts are followed by a reset.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if (mhalt) begin
                for (int j = 0; j < 3; j++) begin
                    chk("rnd_halt_rd", 32'(mem_rd), 0);
                    chk("rnd_halt_wr", 32'(mem_wr), 0);
                    step(1'($urandom_range(0, 1)));
                end
                mem[0] = 8'($urandom_range(0, 239));
                do_reset();
            end
            run_instr($urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
